// File: rtl/f_pc_ctrl.sv
// Fetch-stage PC controller: a two-state request/capture loop with a pending
// redirect register so that the delay-slot fetch completes before a jump lands.
module f_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        d_valid,
    input  logic [2:0]  npc_op,
    input  logic        cmp_suc,
    input  logic [31:0] d_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] ra32,
    input  logic        im_ready,
    output logic        im_req,
    output logic [31:0] f_pc,
    output logic        f_valid,
    output logic        err_bds,
    output logic        dbg_state,
    output logic        dbg_pend_valid,
    output logic [31:0] dbg_pend_pc
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HAVE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic        redirect;
    logic        accept;
    logic [31:0] target;

    always_comb begin
        redirect = d_valid && !stall &&
                   ((npc_op == 3'b001 && cmp_suc) || npc_op == 3'b010 || npc_op == 3'b011);
        case (npc_op)
            3'b001:  target = d_pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
            3'b010:  target = {d_pc[31:28], imm26, 2'b00};
            default: target = ra32;
        endcase
        // A second redirect while one is pending is a delay-slot jump: the first wins.
        accept  = redirect && !pend_valid_q;
        err_bds = redirect && pend_valid_q;

        state_d      = state_q;
        f_pc_d       = f_pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;

        case (state_q)
            S_REQ: begin
                // The outstanding fetch is the delay slot, so only record the target.
                if (accept) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = target;
                end
                if (im_ready) begin
                    state_d = S_HAVE;
                end
            end
            S_HAVE: begin
                if (!stall) begin
                    state_d      = S_REQ;
                    pend_valid_d = 1'b0;
                    if (accept) begin
                        f_pc_d = target;
                    end else if (pend_valid_q) begin
                        f_pc_d = pend_pc_q;
                    end else begin
                        f_pc_d = f_pc_q + 32'd4;
                    end
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            f_pc_q       <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            f_pc_q       <= f_pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign im_req         = (state_q == S_REQ);
    assign f_valid        = (state_q == S_HAVE);
    assign f_pc           = f_pc_q;
    assign dbg_state      = state_q;
    assign dbg_pend_valid = pend_valid_q;
    assign dbg_pend_pc    = pend_pc_q;

endmodule

// File: doc/f_pc_ctrl.md
F_PC_CTRL -- requirements
Module: f_pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port stall, input, 1, hazard-unit stall that freezes the F and D stages.
REQ-005 SHALL have port d_valid, input, 1, meaning the D stage holds a valid instruction.
REQ-006 SHALL have port npc_op, input, 3, D-stage jump class: 000 sequential, 001 branch, 010 j/jal, 011 jr, 1xx reserved.
REQ-007 SHALL have port cmp_suc, input, 1, D-stage branch compare result.
REQ-008 SHALL have ports d_pc, input, 32, the D-stage PC; imm16, input, 16; imm26, input, 26; ra32, input, 32, the forwarded register value for jr.
REQ-009 SHALL have port im_ready, input, 1, instruction memory acknowledge for the current request.
REQ-010 SHALL have port im_req, output, 1, the fetch request.
REQ-011 SHALL have port f_pc, output, 32, the current fetch address.
REQ-012 SHALL have port f_valid, output, 1, meaning the instruction at f_pc is captured and offered to D.
REQ-013 SHALL have port err_bds, output, 1, a one-cycle pulse flagging a redirect while a redirect is already pending.

Function
REQ-014 SHALL implement two states. S_REQ drives im_req=1 and f_valid=0. S_HAVE drives im_req=0 and f_valid=1.
REQ-015 In S_REQ with im_ready=1, the block SHALL move to S_HAVE next cycle; with im_ready=0 it SHALL stay in S_REQ with f_pc held.
REQ-016 Define F advance as state S_HAVE and stall=0. On F advance, the block SHALL load f_pc with the selected next PC and return to S_REQ.
REQ-017 In S_HAVE with stall=1, the block SHALL hold state, f_pc and the pending register.
REQ-018 Define a D redirect as d_valid=1, stall=0, and any of:
- npc_op=001 with cmp_suc=1;
- npc_op=010;
- npc_op=011.
REQ-019 Redirect target SHALL be one of:
- 001: d_pc + 4 + {sext(imm16), 2'b00}, mod 2^32;
- 010: {d_pc[31:28], imm26, 2'b00};
- 011: ra32 unmodified.
REQ-020 The following SHALL never redirect:
- npc_op=000;
- npc_op=001 with cmp_suc=0;
- npc_op 1xx.
REQ-021 The block SHALL implement a pending redirect register (pend_valid, pend_pc) so the delay-slot instruction in F completes before the redirect takes effect.
REQ-022 On a D redirect with pend_valid=0 and no same-cycle F advance, the block SHALL set pend_valid=1 and pend_pc=target.
REQ-023 Next-PC selection on F advance SHALL use this priority:
- a D redirect in the same cycle: its target;
- else pend_valid=1: pend_pc;
- else f_pc+4, wrapping at 2^32.
REQ-024 On F advance, the block SHALL clear pend_valid.
REQ-025 On a D redirect while pend_valid=1, the first target SHALL be kept, the new one discarded, and err_bds SHALL pulse high for exactly that cycle.
REQ-026 A redirect arriving in S_REQ SHALL NOT abort the outstanding fetch; the fetched word is the delay slot.
REQ-027 f_pc SHALL change only on F advance or reset; there is zero-cycle latency from F advance to the new im_req address.

Reset
REQ-028 On reset=1 at a clock edge, the block SHALL set:
- state S_REQ;
- f_pc=RESET_PC;
- f_valid=0, im_req=1 in the following cycle;
- pend_valid=0, pend_pc=0;
- err_bds=0.
REQ-029 Reset SHALL take priority over every other input, including mid-fetch (im_ready=1) and a pending redirect.
REQ-030 Outputs SHALL depend only on registered state, with no combinational path from inputs to im_req, f_valid or f_pc.

Verification
REQ-031 Sequential fetch: after reset, with im_ready=1 every cycle and stall=0, f_pc SHALL step 0x3000, 0x3004, 0x3008, advancing every 2 cycles.
REQ-032 Taken branch: with F at 0x3008 in S_REQ, D at 0x3004, npc_op=001, cmp_suc=1 and imm16=0xFFFE, pend_pc SHALL become 0x3000, and after the 0x3008 fetch completes, f_pc SHALL be 0x3000.
REQ-033 Same-cycle redirect: in S_HAVE with stall=0 and D jal (npc_op=010, imm26=0x0000C40, d_pc=0x3010), f_pc SHALL become 0x0000_3100 directly, with pend_valid staying 0.
REQ-034 Stall hold: with stall=1 for 5 cycles in S_HAVE and a jr in D (ra32=0x4000), f_pc SHALL hold and nothing SHALL be captured; after stall drops, f_pc SHALL become 0x4000.
REQ-035 Double redirect: with pend_valid=1 (pend_pc=0x3100) and another D redirect, err_bds SHALL be 1 for one cycle and pend_pc SHALL remain 0x3100.
REQ-036 Reset mid-operation: with reset during S_REQ and pend_valid=1, the next cycle SHALL show f_pc=0x3000, pend_valid=0 and im_req=1.
